// File: rtl/fpgarr_credit_pkg.sv
//------------------------------------------------------------------------------
// fpgarr_credit_pkg
//
// Shared definitions for the credit-flow-controlled channel blocks
// (credit_rxbuf today, credit_txbuf later).
//
// Contents:
//   CREDIT_DEPTH_DEFAULT - default FIFO depth. On the transmitter side this
//                          is also the initial credit count.
//   credit_ptr_w()       - width of a FIFO read/write pointer for a depth.
//   credit_cnt_w()       - width of an occupancy/credit counter for a depth.
//                          It is one bit wider than a pointer so that the
//                          values 0 and DEPTH can both be represented.
//   credit_depth_ok()    - legality check: power of two and >= 2.
//------------------------------------------------------------------------------
package fpgarr_credit_pkg;

    localparam int unsigned CREDIT_DEPTH_DEFAULT = 4;

    function automatic int unsigned credit_ptr_w(input int unsigned depth);
        // A depth below 2 is illegal, but a zero-width pointer would break
        // elaboration before any check could report the problem.
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned credit_cnt_w(input int unsigned depth);
        return credit_ptr_w(depth) + 1;
    endfunction

    function automatic bit credit_depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage : fpgarr_credit_pkg

// File: rtl/credit_rxbuf.sv
//------------------------------------------------------------------------------
// credit_rxbuf
//
// Receiver end of a credit-flow-controlled channel. The upstream sender
// pushes beats with in_valid only; there is no ready signal, so the sender
// may transmit only while it holds a credit. Beats are stored in a
// DEPTH-entry FIFO and leave on a standard valid/ready channel. Each beat
// removed from the FIFO returns one credit upstream as a registered,
// one-cycle pulse.
//
// Parameters:
//   DATA_WIDTH - payload width
//   DEPTH      - FIFO entries. Must be a power of two and >= 2. Must equal the
//                transmitter's initial credit count.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-high reset
//   in_valid      in   beat present (the sender holds a credit)
//   in_data       in   payload, sampled when in_valid=1
//   credit_return out  one-cycle pulse per freed entry
//   out_valid     out  FIFO non-empty
//   out_data      out  head-of-FIFO payload
//   out_ready     in   downstream accept
//   occupancy     out  current entry count (0..DEPTH)
//   overflow      out  sticky flag, set when a beat is dropped
//
// out_valid and out_data are decoded only from registers, so no
// combinational path runs from in_* or out_ready to any output.
//------------------------------------------------------------------------------
module credit_rxbuf
    import fpgarr_credit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = CREDIT_DEPTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           credit_return,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    input  logic                           out_ready,
    output logic [credit_cnt_w(DEPTH)-1:0] occupancy,
    output logic                           overflow
);

    localparam int unsigned PW = credit_ptr_w(DEPTH);
    localparam int unsigned CW = credit_cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;

    logic full;
    logic remove;
    logic accept;
    logic drop;

    assign full   = (count == CW'(DEPTH));
    assign remove = out_valid && out_ready;
    // When the FIFO is full, a beat is still taken if the head leaves in the
    // same cycle. The write lands in the slot being freed (wr_ptr == rd_ptr
    // when full). The head is read combinationally before the edge, so
    // ordering is preserved.
    assign accept = in_valid && (!full || remove);
    assign drop   = in_valid && full && !remove;

    always_comb begin
        count_next = count;
        unique case ({accept, remove})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Clear the storage as well as the pointers so that out_data
            // reads zero after reset.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            credit_return <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (remove) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count         <= count_next;
            // One pulse per removed beat. A remove happens at most once per
            // cycle, so pulses never need to be merged.
            credit_return <= remove;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign occupancy = count;

`ifdef FORMAL
    // Reference counters. The stimulus is constrained so that each offered
    // beat carries the index of the next accepted beat. Strict FIFO order
    // then means that the head always carries the number of beats already
    // removed.
    logic [31:0] f_in_cnt;
    logic [31:0] f_out_cnt;
    logic [31:0] f_credit_cnt;
    logic        f_past_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_in_cnt     <= '0;
            f_out_cnt    <= '0;
            f_credit_cnt <= '0;
            f_past_ok    <= 1'b1;
        end else begin
            if (accept)        f_in_cnt     <= f_in_cnt + 32'd1;
            if (remove)        f_out_cnt    <= f_out_cnt + 32'd1;
            if (credit_return) f_credit_cnt <= f_credit_cnt + 32'd1;
        end
    end

    f_in_data_seq: assume property (@(posedge clk) disable iff (rst)
        in_valid |-> (in_data == DATA_WIDTH'(f_in_cnt)));

    f_out_hold: assert property (@(posedge clk) disable iff (rst)
        (f_past_ok && out_valid && !out_ready) |=>
            (out_valid && $stable(out_data)));

    f_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= CW'(DEPTH));

    // Each removed beat has either already been counted as a credit or
    // is the pulse currently on credit_return.
    f_credit_match: assert property (@(posedge clk) disable iff (rst)
        f_out_cnt == f_credit_cnt + {31'd0, credit_return});

    f_in_order: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (out_data == DATA_WIDTH'(f_out_cnt)));

    f_depth_legal: assert property (@(posedge clk)
        credit_depth_ok(DEPTH));
`endif

endmodule : credit_rxbuf

// File: tb/tb_credit_rxbuf.sv
//------------------------------------------------------------------------------
// tb_credit_rxbuf
//
// Scoreboard bench for credit_rxbuf (DATA_WIDTH=32, DEPTH=4). The stimulus
// thread pushes the payload of every beat it expects to be accepted. The
// monitor pops an entry on each output handshake and compares it. Every cycle
// the monitor also checks that credit_return is exactly the registered image
// of the previous cycle's handshake.
//------------------------------------------------------------------------------
module tb_credit_rxbuf;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          credit_return;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [2:0]    occupancy;
    logic          overflow;

    credit_rxbuf #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .credit_return (credit_return),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .occupancy     (occupancy),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned   total = 0;
    int unsigned   bad   = 0;
    logic [DW-1:0] exp_q[$];
    int unsigned   rx_cnt     = 0;
    int unsigned   credit_cnt = 0;
    logic          prev_rm  = 1'b0;
    logic          prev_rst = 1'b1;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [DW-1:0] exp_d;
        check("credit_return", {31'd0, credit_return},
              {31'd0, prev_rm && !prev_rst});
        if (credit_return) credit_cnt++;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", out_data, 32'hDEAD_BEEF);
            end else begin
                exp_d = exp_q.pop_front();
                check("out_data", out_data, exp_d);
                rx_cnt++;
            end
        end
        prev_rm  = out_valid && out_ready;
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one beat for one cycle and records it as expected.
    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int unsigned n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    task automatic do_reset(input int unsigned n);
        rst = 1'b1;
        exp_q.delete();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        int unsigned credits;
        int unsigned sent;
        int unsigned cycles;

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_00AA;
        out_ready = 1'b0;

        // Reset is held for 2 cycles with in_valid high: nothing may be
        // accepted.
        repeat (2) tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_occupancy", {29'd0, occupancy}, 32'd0);
        check("rst_overflow",  {31'd0, overflow}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("idle_occupancy", {29'd0, occupancy}, 32'd0);

        // Fill with 0..3 while the output is stalled.
        for (int unsigned i = 0; i < 4; i++) send(i);
        check("fill_occupancy", {29'd0, occupancy}, 32'd4);
        check("fill_out_valid", {31'd0, out_valid}, 32'd1);
        check("fill_out_data",  out_data, 32'd0);
        tick();
        check("hold_out_data",  out_data, 32'd0);

        // Drain 4 beats back to back.
        credit_cnt = 0;
        drain(4);
        check("drain_occupancy", {29'd0, occupancy}, 32'd0);
        tick();
        check("drain_credits", credit_cnt, 32'd4);

        // Full FIFO with a beat offered while the head leaves: beat 4 is
        // accepted into the freed slot.
        for (int unsigned i = 0; i < 4; i++) send(i);
        out_ready = 1'b1;
        send(32'd4);
        out_ready = 1'b0;
        check("full_rm_occupancy", {29'd0, occupancy}, 32'd4);
        check("full_rm_overflow",  {31'd0, overflow}, 32'd0);
        check("full_rm_head",      out_data, 32'd1);
        drain(4);

        // Full FIFO with no removal: beat 9 is dropped.
        for (int unsigned i = 0; i < 4; i++) send(i);
        in_valid = 1'b1;
        in_data  = 32'd9;
        tick();
        in_valid = 1'b0;
        check("drop_overflow",  {31'd0, overflow}, 32'd1);
        check("drop_occupancy", {29'd0, occupancy}, 32'd4);
        drain(4);
        check("sticky_overflow", {31'd0, overflow}, 32'd1);
        check("post_drop_empty", {29'd0, occupancy}, 32'd0);
        do_reset(1);
        check("cleared_overflow", {31'd0, overflow}, 32'd0);

        // Streaming: the sender holds 4 credits. A returned credit becomes
        // usable one cycle after it is seen.
        credits    = DEPTH;
        sent       = 0;
        cycles     = 0;
        rx_cnt     = 0;
        credit_cnt = 0;
        while ((rx_cnt < 100) && (cycles < 2000)) begin
            if ((credits > 0) && (sent < 100)) begin
                credits--;
                in_valid = 1'b1;
                in_data  = 32'h100 + sent;
                exp_q.push_back(32'h100 + sent);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(1, 0) == 1);
            if (credit_return) credits++;
            tick();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_received", rx_cnt, 32'd100);
        tick();
        check("stream_credits",  credit_cnt, 32'd100);
        check("stream_overflow", {31'd0, overflow}, 32'd0);
        check("stream_empty",    {29'd0, occupancy}, 32'd0);

        // Reset with 3 entries stored and the output ready: the contents are
        // flushed and no credit pulse is issued.
        for (int unsigned i = 0; i < 3; i++) send(32'h50 + i);
        check("pre_rst_occupancy", {29'd0, occupancy}, 32'd3);
        out_ready = 1'b1;
        do_reset(1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_occupancy", {29'd0, occupancy}, 32'd0);
        check("mid_rst_credit",    {31'd0, credit_return}, 32'd0);
        tick();
        check("post_rst_credit",   {31'd0, credit_return}, 32'd0);
        out_ready = 1'b0;
        tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_credit_rxbuf
